// File: rtl/obi_mem_responder_pkg.sv
// Shared types and helpers for the OBI memory responder: the queued response
// entry and the byte-to-word address conversion.
package obi_mem_responder_pkg;

  localparam int RESP_CNT_WIDTH = 4;

  typedef struct packed {
    logic [31:0]               rdata;
    logic                      err;
    logic [RESP_CNT_WIDTH-1:0] remain;
  } resp_entry_t;

  // Word index of a byte address, keeping only the low aw word-address bits.
  function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                             input int unsigned aw);
    return (byte_addr >> 2) & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage

// File: rtl/obi_resp_fifo.sv
// In-order response FIFO; every live entry counts its remaining latency down
// to zero, and only the head may leave.
module obi_resp_fifo
  import obi_mem_responder_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  resp_entry_t       push_entry,
  input  logic              pop,
  output resp_entry_t       head,
  output logic              full,
  output logic [PTR_W:0]    count
);

  resp_entry_t          entries [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [DEPTH-1:0]     entry_valid;

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = {1'b0, PTR_W'(i) - rd_ptr} < count;
    end
  end

  assign head = entries[rd_ptr];
  assign full = (count == (PTR_W + 1)'(DEPTH));

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && entries[i].remain != '0) begin
        entries[i].remain <= entries[i].remain - 1'b1;
      end
    end
    if (push) begin
      entries[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/obi_mem_responder.sv
// Target end of an OBI req/gnt/rvalid port backed by a word SRAM, with
// programmable grant delay and per-transaction response latency.
module obi_mem_responder
  import obi_mem_responder_pkg::*;
#(
  parameter  int MEM_ADDR_WIDTH  = 12,
  parameter  int MAX_OUTSTANDING = 4,
  parameter  int CNT_WIDTH       = 4,
  localparam int OCC_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic [31:0]          addr_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [31:0]          wdata_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [31:0]          rdata_o,
  output logic                 err_o,
  input  logic [CNT_WIDTH-1:0] gnt_delay_i,
  input  logic [CNT_WIDTH-1:0] rvalid_latency_i,
  output logic [OCC_W-1:0]     outstanding_o
);

  logic [31:0]               mem [2**MEM_ADDR_WIDTH];
  logic [CNT_WIDTH-1:0]      wcnt;
  logic [MEM_ADDR_WIDTH-1:0] widx;
  logic [31:0]               rd_word;
  logic                      addr_err;
  logic                      fifo_full;
  logic                      pop;
  resp_entry_t               head;
  resp_entry_t               push_entry;

  assign widx     = MEM_ADDR_WIDTH'(word_index(addr_i, MEM_ADDR_WIDTH));
  assign addr_err = |addr_i[31:MEM_ADDR_WIDTH+2];
  assign rd_word  = mem[widx];

  // Handshake: a transaction moves when req_i && gnt_o; a response is
  // presented for exactly the one cycle rvalid_o is high, with no back-pressure.
  // Full blocks the grant even when the head pops in the same cycle.
  assign gnt_o = !rst_i && req_i && (wcnt >= gnt_delay_i) && !fifo_full;

  always_comb begin
    push_entry.rdata  = (we_i || addr_err) ? '0 : rd_word;
    push_entry.err    = addr_err;
    push_entry.remain = (rvalid_latency_i == '0) ? '0
                      : RESP_CNT_WIDTH'(rvalid_latency_i - 1'b1);
  end

  // Saturating so a long full-FIFO stall cannot wrap the count below the delay.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wcnt <= '0;
    end else if (!req_i || gnt_o) begin
      wcnt <= '0;
    end else if (wcnt != '1) begin
      wcnt <= wcnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (gnt_o && we_i && !addr_err) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem[widx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  obi_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (gnt_o),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .count      (outstanding_o)
  );

  assign pop      = !rst_i && (outstanding_o != '0) && (head.remain == '0);
  assign rvalid_o = pop;
  assign rdata_o  = pop ? head.rdata : '0;
  assign err_o    = pop && head.err;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: directed scenarios then random traffic, all
// compared every cycle against a transaction-level model of the responder.
module tb_obi_mem_responder;

  localparam int AW      = 12;
  localparam int MAX_OUT = 4;
  localparam int CW      = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [31:0]   addr;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic          gnt;
  logic          rvalid;
  logic [31:0]   rdata;
  logic          err;
  logic [CW-1:0] gnt_delay;
  logic [CW-1:0] rvalid_latency;
  logic [$clog2(MAX_OUT):0] outstanding;

  obi_mem_responder #(
    .MEM_ADDR_WIDTH  (AW),
    .MAX_OUTSTANDING (MAX_OUT),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_i            (req),
    .addr_i           (addr),
    .we_i             (we),
    .be_i             (be),
    .wdata_i          (wdata),
    .gnt_o            (gnt),
    .rvalid_o         (rvalid),
    .rdata_o          (rdata),
    .err_o            (err),
    .gnt_delay_i      (gnt_delay),
    .rvalid_latency_i (rvalid_latency),
    .outstanding_o    (outstanding)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: memory image plus the ordered list of owed responses
  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] model_mem [4096];
  int          m_wait;
  int          cyc;
  logic        last_exp_gnt;
  logic [31:0] last_rdata;
  logic        last_err;
  int          rv_count;
  int          vectors;
  int          miscompares;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, expv, cyc);
    end
  endtask

  // One clock: compare DUT against the model mid-cycle, then advance the model.
  task automatic tick();
    logic        exp_gnt;
    logic        exp_rv;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        a_err;
    int          w;
    resp_t       r;
    @(negedge clk);
    exp_gnt = !rst && req && (m_wait >= int'(gnt_delay)) && (exp_q.size() < MAX_OUT);
    exp_rv  = !rst && (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    exp_rd  = exp_rv ? exp_q[0].data : 32'h0;
    exp_err = exp_rv ? exp_q[0].err : 1'b0;
    check("gnt", {31'b0, gnt}, {31'b0, exp_gnt});
    check("rvalid", {31'b0, rvalid}, {31'b0, exp_rv});
    check("rdata", rdata, exp_rd);
    check("err", {31'b0, err}, {31'b0, exp_err});
    if (!rst) check("outstanding", 32'(outstanding), 32'(exp_q.size()));
    if (rvalid === 1'b1) begin
      last_rdata = rdata;
      last_err   = err;
      rv_count++;
    end
    last_exp_gnt = exp_gnt;
    if (rst) begin
      exp_q.delete();
      m_wait = 0;
    end else begin
      if (exp_rv) void'(exp_q.pop_front());
      if (exp_gnt) begin
        a_err  = |addr[31:AW+2];
        w      = int'(addr[AW+1:2]);
        r.due  = cyc + ((rvalid_latency == 0) ? 1 : int'(rvalid_latency));
        r.err  = a_err;
        r.data = (we || a_err) ? 32'h0 : model_mem[w];
        exp_q.push_back(r);
        if (we && !a_err) begin
          for (int k = 0; k < 4; k++) begin
            if (be[k]) model_mem[w][8*k +: 8] = wdata[8*k +: 8];
          end
        end
      end
      if (exp_gnt || !req) m_wait = 0;
      else if (m_wait < 15) m_wait++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // driver tasks
  task automatic do_txn(input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, output int waits);
    logic granted;
    req = 1'b1; addr = a; we = w; be = b; wdata = d;
    waits = 0;
    granted = 1'b0;
    while (!granted && waits < 100) begin
      tick();
      if (last_exp_gnt) granted = 1'b1;
      else waits++;
    end
    check("grant_timeout", {31'b0, granted}, 32'd1);
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    int n;
    req = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    tick();
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int          wt;
    int          w5;
    int          rv_snap;
    logic [31:0] a;

    vectors = 0; miscompares = 0; cyc = 0; m_wait = 0; rv_count = 0;
    last_rdata = '0; last_err = 1'b0; last_exp_gnt = 1'b0;
    rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0;
    gnt_delay = '0; rvalid_latency = 4'd1;
    #1;
    tick(); tick();
    rst = 1'b0;
    idle(2);

    // delay 0, latency 1: write then read back next cycle
    do_txn(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, wt);
    check("same_cycle_grant_wr", 32'(wt), 32'd0);
    do_txn(32'h10, 1'b0, 4'hF, 32'h0, wt);
    check("same_cycle_grant_rd", 32'(wt), 32'd0);
    idle(1);
    check("read_0x10", last_rdata, 32'hDEADBEEF);
    check("read_0x10_err", {31'b0, last_err}, 32'd0);

    // byte enables
    do_txn(32'h20, 1'b1, 4'hF, 32'h11223344, wt);
    do_txn(32'h20, 1'b1, 4'b0101, 32'hAABBCCDD, wt);
    do_txn(32'h20, 1'b0, 4'hF, 32'h0, wt);
    drain();
    check("byte_enable_merge", last_rdata, 32'h11BB33DD);

    // grant delay 3, then an abandoned request that must clear the counter
    gnt_delay = 4'd3;
    do_txn(32'h10, 1'b0, 4'hF, 32'h0, wt);
    check("gnt_delay3_wait", 32'(wt), 32'd3);
    idle(1);
    req = 1'b1; addr = 32'h10; we = 1'b0;
    tick(); tick();
    idle(1);
    do_txn(32'h10, 1'b0, 4'hF, 32'h0, wt);
    check("gnt_delay3_after_drop", 32'(wt), 32'd3);
    drain();
    gnt_delay = '0;

    // latency 8, five back-to-back reads against a four-deep FIFO
    rvalid_latency = 4'd8;
    for (int i = 0; i < 4; i++) begin
      do_txn(32'h10, 1'b0, 4'hF, 32'h0, wt);
      check("b2b_grant", 32'(wt), 32'd0);
    end
    do_txn(32'h20, 1'b0, 4'hF, 32'h0, w5);
    check("fifth_grant_wait", 32'(w5), 32'd5);
    drain();
    check("fifth_read_data", last_rdata, 32'h11BB33DD);
    rvalid_latency = 4'd1;

    // out-of-range write must not touch word 0
    do_txn(32'h0, 1'b1, 4'hF, 32'h01234567, wt);
    do_txn(32'h0010_0000, 1'b1, 4'hF, 32'hFFFFFFFF, wt);
    idle(1);
    check("oor_err", {31'b0, last_err}, 32'd1);
    check("oor_rdata", last_rdata, 32'h0);
    do_txn(32'h0, 1'b0, 4'hF, 32'h0, wt);
    idle(1);
    check("word0_preserved", last_rdata, 32'h01234567);

    // reset with three reads in flight
    rvalid_latency = 4'd6;
    for (int i = 0; i < 3; i++) do_txn(32'h10, 1'b0, 4'hF, 32'h0, wt);
    req = 1'b0;
    rv_snap = rv_count;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(10);
    check("no_rvalid_after_reset", 32'(rv_count), 32'(rv_snap));
    check("outstanding_after_reset", 32'(outstanding), 32'd0);
    rvalid_latency = 4'd1;
    do_txn(32'h10, 1'b0, 4'hF, 32'h0, wt);
    idle(1);
    check("mem_kept_over_reset", last_rdata, 32'hDEADBEEF);

    // random traffic over a small initialised window plus stray out-of-range hits
    for (int i = 0; i < 16; i++) begin
      do_txn(32'(i * 4), 1'b1, 4'hF, $urandom, wt);
    end
    for (int t = 0; t < 300; t++) begin
      gnt_delay      = CW'($urandom_range(0, 3));
      rvalid_latency = CW'($urandom_range(0, 9));
      if ($urandom_range(0, 9) == 0) begin
        a = {8'($urandom_range(1, 255)), 24'h0} | 32'($urandom_range(0, 63));
      end else begin
        a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      end
      do_txn(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, wt);
      idle($urandom_range(0, 2));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
